csr_trap_ctrl: RTL and testbench

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

---
 rtl/csr_trap_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: commit-side sequencer for CSR instructions, synchronous
// exceptions, interrupts and mret.
// Arbitrates once per IDLE cycle, issues CSR accesses to the CSR file (TMU),
// and in TRAP pulses the trap strobe together with the redirect target.
// Optional feature macro: CSR_TRAP_ILLEGAL_EN. When it is defined, a CSR
// access that the TMU rejects becomes an illegal-instruction trap (cause 2).
// dbg_state_o exposes the FSM state: 0 IDLE, 1 CSR_ISSUE, 2 CSR_WAIT, 3 TRAP.
// Handshake: csr_req is accepted on a rising edge where csr_req_valid_i and
// csr_req_ready_o are both 1. Trap requesters (excp/irq/mret) have no ready
// and must hold their request until the matching take_*/mret_o pulse is seen.
module csr_trap_ctrl (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_ni,
    input  logic        csr_req_valid_i,
    output logic        csr_req_ready_o,
    input  logic [11:0] csr_req_addr_i,
    input  logic [1:0]  csr_req_op_i,
    input  logic        csr_req_wr_i,
    input  logic [31:0] csr_req_data_i,
    output logic        csr_resp_valid_o,
    output logic [31:0] csr_resp_data_o,
    output logic        csr_resp_excp_o,
    input  logic        excp_valid_i,
    input  logic [29:0] excp_pc_i,
    input  logic [3:0]  excp_cause_i,
    input  logic [31:0] excp_tval_i,
    input  logic        mret_valid_i,
    input  logic [29:0] irq_pc_i,
    input  logic [2:0]  mip_i,
    input  logic        mie_i,
    output logic        tmu_valid_o,
    output logic [11:0] tmu_address_o,
    output logic [1:0]  tmu_opcode_o,
    output logic        tmu_wr_en_o,
    output logic [31:0] tmu_data_o,
    input  logic        tmu_done_i,
    input  logic        tmu_excp_i,
    input  logic [31:0] tmu_data_i,
    output logic        take_exception_o,
    output logic        take_interrupt_o,
    output logic        mret_o,
    output logic [29:0] tmu_epc_o,
    output logic [31:0] tmu_mtval_o,
    output logic [3:0]  tmu_mcause_o,
    input  logic [31:0] mtvec_i,
    input  logic [29:0] mepc_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CSR_ISSUE = 2'd1;
    localparam logic [1:0] S_CSR_WAIT  = 2'd2;
    localparam logic [1:0] S_TRAP      = 2'd3;

    logic [1:0]  r_state;
    logic        r_take_exc;
    logic        r_take_irq;
    logic        r_mret;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic [29:0] r_epc;
    logic [31:0] r_mtval;
    logic [3:0]  r_mcause;
    logic        r_tmu_valid;
    logic [11:0] r_tmu_addr;
    logic [1:0]  r_tmu_op;
    logic        r_tmu_wr;
    logic [31:0] r_tmu_data;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_resp_excp;
`ifdef CSR_TRAP_ILLEGAL_EN
    logic [29:0] r_csr_pc;
`endif

    logic        w_idle;
    logic        w_irq_pend;
    logic        w_win_excp;
    logic        w_win_irq;
    logic        w_win_mret;
    logic        w_win_csr;
    logic [3:0]  w_irq_cause;
    logic [31:0] w_mtvec_base;
    logic [31:0] w_irq_target;

    assign w_idle     = (r_state == S_IDLE);
    assign w_irq_pend = mie_i & (|mip_i);

    // Fixed priority: exception > interrupt > mret > CSR request.
    assign w_win_excp = w_idle & excp_valid_i;
    assign w_win_irq  = w_idle & ~excp_valid_i & w_irq_pend;
    assign w_win_mret = w_idle & ~excp_valid_i & ~w_irq_pend & mret_valid_i;

    // Ready is held low while reset is asserted so every output reads 0.
    assign csr_req_ready_o = cpu_reset_ni & w_idle & ~excp_valid_i & ~w_irq_pend & ~mret_valid_i;
    assign w_win_csr       = csr_req_valid_i & csr_req_ready_o;

    // Interrupt cause selection: external, then software, then timer.
    always_comb begin
        w_irq_cause = 4'd0;
        if (mip_i[2]) begin
            w_irq_cause = 4'd11;
        end else if (mip_i[0]) begin
            w_irq_cause = 4'd3;
        end else if (mip_i[1]) begin
            w_irq_cause = 4'd7;
        end
    end

    // Vectored mode (mtvec[1:0] == 01) offsets interrupts by 4*cause; the
    // 32-bit add wraps naturally.
    assign w_mtvec_base = {mtvec_i[31:2], 2'b00};
    assign w_irq_target = (mtvec_i[1:0] == 2'b01) ?
                          (w_mtvec_base + {26'd0, w_irq_cause, 2'b00}) : w_mtvec_base;

    // FSM plus all registered outputs; pulse outputs default low every cycle.
    always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
            r_state          <= S_IDLE;
            r_take_exc       <= 1'b0;
            r_take_irq       <= 1'b0;
            r_mret           <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_epc            <= 30'd0;
            r_mtval          <= 32'd0;
            r_mcause         <= 4'd0;
            r_tmu_valid      <= 1'b0;
            r_tmu_addr       <= 12'd0;
            r_tmu_op         <= 2'd0;
            r_tmu_wr         <= 1'b0;
            r_tmu_data       <= 32'd0;
            r_resp_valid     <= 1'b0;
            r_resp_data      <= 32'd0;
            r_resp_excp      <= 1'b0;
`ifdef CSR_TRAP_ILLEGAL_EN
            r_csr_pc         <= 30'd0;
`endif
        end else begin
            r_take_exc       <= 1'b0;
            r_take_irq       <= 1'b0;
            r_mret           <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_tmu_valid      <= 1'b0;
            r_resp_valid     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_win_excp) begin
                        r_state          <= S_TRAP;
                        r_take_exc       <= 1'b1;
                        r_epc            <= excp_pc_i;
                        r_mcause         <= excp_cause_i;
                        r_mtval          <= excp_tval_i;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_mtvec_base;
                    end else if (w_win_irq) begin
                        r_state          <= S_TRAP;
                        r_take_irq       <= 1'b1;
                        r_epc            <= irq_pc_i;
                        r_mcause         <= w_irq_cause;
                        r_mtval          <= 32'd0;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_irq_target;
                    end else if (w_win_mret) begin
                        r_state          <= S_TRAP;
                        r_mret           <= 1'b1;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= {mepc_i, 2'b00};
                    end else if (w_win_csr) begin
                        r_state     <= S_CSR_ISSUE;
                        r_tmu_valid <= 1'b1;
                        r_tmu_addr  <= csr_req_addr_i;
                        r_tmu_op    <= csr_req_op_i;
                        r_tmu_wr    <= csr_req_wr_i;
                        r_tmu_data  <= csr_req_data_i;
`ifdef CSR_TRAP_ILLEGAL_EN
                        r_csr_pc    <= irq_pc_i;
`endif
                    end
                end
                S_CSR_ISSUE: begin
                    r_state <= S_CSR_WAIT;
                end
                S_CSR_WAIT: begin
                    if (tmu_done_i) begin
`ifdef CSR_TRAP_ILLEGAL_EN
                        if (tmu_excp_i) begin
                            // Rejected access: raise illegal instruction instead of responding.
                            r_state          <= S_TRAP;
                            r_take_exc       <= 1'b1;
                            r_epc            <= r_csr_pc;
                            r_mcause         <= 4'd2;
                            r_mtval          <= 32'd0;
                            r_redirect_valid <= 1'b1;
                            r_redirect_pc    <= w_mtvec_base;
                        end else begin
                            r_state      <= S_IDLE;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= tmu_data_i;
                            r_resp_excp  <= 1'b0;
                        end
`else
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= tmu_data_i;
                        r_resp_excp  <= tmu_excp_i;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign csr_resp_valid_o = r_resp_valid;
    assign csr_resp_data_o  = r_resp_data;
    assign csr_resp_excp_o  = r_resp_excp;
    assign tmu_valid_o      = r_tmu_valid;
    assign tmu_address_o    = r_tmu_addr;
    assign tmu_opcode_o     = r_tmu_op;
    assign tmu_wr_en_o      = r_tmu_wr;
    assign tmu_data_o       = r_tmu_data;
    assign take_exception_o = r_take_exc;
    assign take_interrupt_o = r_take_irq;
    assign mret_o           = r_mret;
    assign tmu_epc_o        = r_epc;
    assign tmu_mtval_o      = r_mtval;
    assign tmu_mcause_o     = r_mcause;
    assign redirect_valid_o = r_redirect_valid;
    assign redirect_pc_o    = r_redirect_pc;
    assign busy_o           = ~w_idle;
    assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed vectors, expected events queued by the
// drivers, a negedge monitor pops and compares every output pulse.
module tb_csr_trap_ctrl;

    localparam int W = 104;
    localparam logic [3:0] K_EXC   = 4'd1;
    localparam logic [3:0] K_IRQ   = 4'd2;
    localparam logic [3:0] K_MRET  = 4'd3;
    localparam logic [3:0] K_ISSUE = 4'd4;
    localparam logic [3:0] K_RESP  = 4'd5;

    logic        clk;
    logic        rst_n;
    logic        csr_req_valid_i;
    logic        csr_req_ready_o;
    logic [11:0] csr_req_addr_i;
    logic [1:0]  csr_req_op_i;
    logic        csr_req_wr_i;
    logic [31:0] csr_req_data_i;
    logic        csr_resp_valid_o;
    logic [31:0] csr_resp_data_o;
    logic        csr_resp_excp_o;
    logic        excp_valid_i;
    logic [29:0] excp_pc_i;
    logic [3:0]  excp_cause_i;
    logic [31:0] excp_tval_i;
    logic        mret_valid_i;
    logic [29:0] irq_pc_i;
    logic [2:0]  mip_i;
    logic        mie_i;
    logic        tmu_valid_o;
    logic [11:0] tmu_address_o;
    logic [1:0]  tmu_opcode_o;
    logic        tmu_wr_en_o;
    logic [31:0] tmu_data_o;
    logic        tmu_done_i;
    logic        tmu_excp_i;
    logic [31:0] tmu_data_i;
    logic        take_exception_o;
    logic        take_interrupt_o;
    logic        mret_o;
    logic [29:0] tmu_epc_o;
    logic [31:0] tmu_mtval_o;
    logic [3:0]  tmu_mcause_o;
    logic [31:0] mtvec_i;
    logic [29:0] mepc_i;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;
    logic [1:0]  dbg_state_o;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    csr_trap_ctrl dut (
        .cpu_clock_i(clk), .cpu_reset_ni(rst_n),
        .csr_req_valid_i(csr_req_valid_i), .csr_req_ready_o(csr_req_ready_o),
        .csr_req_addr_i(csr_req_addr_i), .csr_req_op_i(csr_req_op_i),
        .csr_req_wr_i(csr_req_wr_i), .csr_req_data_i(csr_req_data_i),
        .csr_resp_valid_o(csr_resp_valid_o), .csr_resp_data_o(csr_resp_data_o),
        .csr_resp_excp_o(csr_resp_excp_o),
        .excp_valid_i(excp_valid_i), .excp_pc_i(excp_pc_i),
        .excp_cause_i(excp_cause_i), .excp_tval_i(excp_tval_i),
        .mret_valid_i(mret_valid_i), .irq_pc_i(irq_pc_i), .mip_i(mip_i), .mie_i(mie_i),
        .tmu_valid_o(tmu_valid_o), .tmu_address_o(tmu_address_o),
        .tmu_opcode_o(tmu_opcode_o), .tmu_wr_en_o(tmu_wr_en_o), .tmu_data_o(tmu_data_o),
        .tmu_done_i(tmu_done_i), .tmu_excp_i(tmu_excp_i), .tmu_data_i(tmu_data_i),
        .take_exception_o(take_exception_o), .take_interrupt_o(take_interrupt_o),
        .mret_o(mret_o), .tmu_epc_o(tmu_epc_o), .tmu_mtval_o(tmu_mtval_o),
        .tmu_mcause_o(tmu_mcause_o), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .busy_o(busy_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] ev(input logic [3:0] k, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c,
                                        input logic [3:0] d);
        return {k, a, b, c, d};
    endfunction

    function automatic logic pick(input int sel);
        case (sel)
            0: return take_exception_o;
            1: return take_interrupt_o;
            2: return mret_o;
            3: return tmu_valid_o;
            default: return csr_resp_valid_o;
        endcase
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic sb_compare(input string name, input logic [W-1:0] obs);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: unexpected event 0x%026h with empty queue", name, obs);
        end else begin
            e = exp_q.pop_front();
            if (e !== obs) begin
                failures++;
                $display("FAIL %s: got 0x%026h expected 0x%026h", name, obs, e);
            end
        end
    endtask

    always @(negedge clk) begin
        int n;
        if (rst_n) begin
            n = int'(take_exception_o) + int'(take_interrupt_o) + int'(mret_o)
              + int'(tmu_valid_o) + int'(csr_resp_valid_o);
            if (n > 0 || redirect_valid_o) begin
                checks++;
                if (n != 1 || redirect_valid_o !== (take_exception_o | take_interrupt_o | mret_o)) begin
                    failures++;
                    $display("FAIL pulse_excl: pulses=%0d redirect=%0b, required one pulse with redirect only on trap",
                             n, redirect_valid_o);
                end
            end
            if (take_exception_o)
                sb_compare("take_exception", ev(K_EXC, redirect_pc_o, tmu_mtval_o, {2'b00, tmu_epc_o}, tmu_mcause_o));
            if (take_interrupt_o)
                sb_compare("take_interrupt", ev(K_IRQ, redirect_pc_o, tmu_mtval_o, {2'b00, tmu_epc_o}, tmu_mcause_o));
            if (mret_o)
                sb_compare("mret", ev(K_MRET, redirect_pc_o, 32'd0, 32'd0, 4'd0));
            if (tmu_valid_o)
                sb_compare("tmu_issue", ev(K_ISSUE, {20'd0, tmu_address_o}, tmu_data_o,
                                           {29'd0, tmu_opcode_o, tmu_wr_en_o}, 4'd0));
            if (csr_resp_valid_o)
                sb_compare("csr_resp", ev(K_RESP, csr_resp_data_o, 32'd0, 32'd0, {3'd0, csr_resp_excp_o}));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_pulse(input int sel, input string name);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (pick(sel)) return;
        end
        checks++;
        failures++;
        $display("FAIL %s: timeout waiting 50 cycles, got no pulse expected one", name);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val(name, exp_q.size(), 0);
    endtask

    // CSR request; accept expected on the first edge (no trap pending).
    task automatic csr_op(input logic [11:0] addr, input logic [1:0] op, input logic wr,
                          input logic [31:0] data, input int delay,
                          input logic [31:0] rdata, input logic rexcp, input logic [2:0] raise_mip);
        csr_req_valid_i = 1'b1;
        csr_req_addr_i  = addr;
        csr_req_op_i    = op;
        csr_req_wr_i    = wr;
        csr_req_data_i  = data;
        @(posedge clk); #1;
        csr_req_valid_i = 1'b0;
        csr_req_data_i  = 32'd0;
        check_val("csr_accept_lat", {31'd0, tmu_valid_o}, 32'd1);
        if (raise_mip != 3'd0) begin
            mie_i = 1'b1;
            mip_i = raise_mip;
        end
        repeat (delay) @(posedge clk);
        #1;
        tmu_done_i = 1'b1;
        tmu_data_i = rdata;
        tmu_excp_i = rexcp;
        @(posedge clk); #1;
        tmu_done_i = 1'b0;
        tmu_data_i = 32'd0;
        tmu_excp_i = 1'b0;
    endtask

    task automatic irq_case(input logic [31:0] mtvec, input logic [2:0] mip,
                            input logic [29:0] pc, input logic [31:0] target, input logic [3:0] cause);
        exp_q.push_back(ev(K_IRQ, target, 32'd0, {2'b00, pc}, cause));
        mtvec_i  = mtvec;
        irq_pc_i = pc;
        mie_i    = 1'b1;
        mip_i    = mip;
        wait_pulse(1, "irq_take");
        mie_i = 1'b0;
        mip_i = 3'd0;
        drain("irq_drain");
    endtask

    // ---------------- stimulus ----------------
    logic [187:0] all_out;
    assign all_out = {csr_req_ready_o, csr_resp_valid_o, csr_resp_data_o, csr_resp_excp_o,
                      tmu_valid_o, tmu_address_o, tmu_opcode_o, tmu_wr_en_o, tmu_data_o,
                      take_exception_o, take_interrupt_o, mret_o, tmu_epc_o, tmu_mtval_o,
                      tmu_mcause_o, redirect_valid_o, redirect_pc_o, busy_o, dbg_state_o};

    initial begin
        rst_n = 1'b0;
        csr_req_valid_i = 1'b0; csr_req_addr_i = 12'd0; csr_req_op_i = 2'd0;
        csr_req_wr_i = 1'b0; csr_req_data_i = 32'd0;
        excp_valid_i = 1'b0; excp_pc_i = 30'd0; excp_cause_i = 4'd0; excp_tval_i = 32'd0;
        mret_valid_i = 1'b0; irq_pc_i = 30'd0; mip_i = 3'd0; mie_i = 1'b0;
        tmu_done_i = 1'b0; tmu_excp_i = 1'b0; tmu_data_i = 32'd0;
        mtvec_i = 32'h8000_0001; mepc_i = 30'd0;

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (all_out !== 188'd0) begin
            failures++;
            $display("FAIL reset_outputs: got 0x%047h expected all zero", all_out);
        end
        rst_n = 1'b1;

        // CSR write right after reset: accepted on the first edge, done 2 cycles
        // after tmu_valid, interrupt raised mid-wait taken only after the response.
        irq_pc_i = 30'h0000_0200;
        exp_q.push_back(ev(K_ISSUE, 32'h0000_0340, 32'h0000_1234, 32'h0000_0003, 4'd0));
        exp_q.push_back(ev(K_RESP, 32'h0000_0055, 32'd0, 32'd0, 4'd0));
        exp_q.push_back(ev(K_IRQ, 32'h8000_002C, 32'd0, 32'h0000_0200, 4'd11));
        csr_op(12'h340, 2'd1, 1'b1, 32'h0000_1234, 2, 32'h0000_0055, 1'b0, 3'b100);
        wait_pulse(1, "irq_after_csr");
        mie_i = 1'b0;
        mip_i = 3'd0;
        drain("csr_irq_drain");

        // Exception and mret together: exception wins.
        exp_q.push_back(ev(K_EXC, 32'h8000_0000, 32'h0000_DEAD, 32'h0000_0100, 4'd2));
        mtvec_i = 32'h8000_0001;
        excp_valid_i = 1'b1; excp_pc_i = 30'h100; excp_cause_i = 4'd2; excp_tval_i = 32'hDEAD;
        mret_valid_i = 1'b1;
        wait_pulse(0, "excp_take");
        excp_valid_i = 1'b0;
        mret_valid_i = 1'b0;
        drain("excp_drain");

        // Interrupt cause priority and vectoring.
        irq_case(32'h8000_0001, 3'b111, 30'h0000_0300, 32'h8000_002C, 4'd11);
        irq_case(32'h0000_1000, 3'b010, 30'h0000_0304, 32'h0000_1000, 4'd7);
        irq_case(32'h0000_2001, 3'b011, 30'h0000_0308, 32'h0000_200C, 4'd3);
        irq_case(32'hFFFF_FFFD, 3'b100, 30'h0000_030C, 32'h0000_0028, 4'd11);

        // mret redirect to mepc.
        exp_q.push_back(ev(K_MRET, 32'h0000_0100, 32'd0, 32'd0, 4'd0));
        mepc_i = 30'h0000_0040;
        mret_valid_i = 1'b1;
        wait_pulse(2, "mret_take");
        mret_valid_i = 1'b0;
        drain("mret_drain");

        // Masked interrupt (mie=0) must not block a CSR read.
        mie_i = 1'b0;
        mip_i = 3'b111;
        exp_q.push_back(ev(K_ISSUE, 32'h0000_0300, 32'd0, 32'h0000_0004, 4'd0));
        exp_q.push_back(ev(K_RESP, 32'hCAFE_F00D, 32'd0, 32'd0, 4'd0));
        csr_op(12'h300, 2'd2, 1'b0, 32'd0, 1, 32'hCAFE_F00D, 1'b0, 3'd0);
        mip_i = 3'd0;
        drain("masked_drain");

        // TMU rejects the access.
        irq_pc_i = 30'h0000_0444;
        mtvec_i  = 32'h8000_0001;
        exp_q.push_back(ev(K_ISSUE, 32'h0000_0FFF, 32'h0000_0077, 32'h0000_0003, 4'd0));
`ifdef CSR_TRAP_ILLEGAL_EN
        exp_q.push_back(ev(K_EXC, 32'h8000_0000, 32'd0, 32'h0000_0444, 4'd2));
`else
        exp_q.push_back(ev(K_RESP, 32'h0000_0099, 32'd0, 32'd0, 4'd1));
`endif
        csr_op(12'hFFF, 2'd1, 1'b1, 32'h0000_0077, 1, 32'h0000_0099, 1'b1, 3'd0);
        drain("illegal_drain");

        // Reset during CSR_WAIT: all outputs clear, no response afterwards.
        exp_q.push_back(ev(K_ISSUE, 32'h0000_0341, 32'hA5A5_0001, 32'h0000_0003, 4'd0));
        csr_req_valid_i = 1'b1; csr_req_addr_i = 12'h341; csr_req_op_i = 2'd1;
        csr_req_wr_i = 1'b1; csr_req_data_i = 32'hA5A5_0001;
        @(posedge clk); #1;
        csr_req_valid_i = 1'b0;
        check_val("rst_accept_lat", {31'd0, tmu_valid_o}, 32'd1);
        @(posedge clk); #1;
        check_val("rst_in_wait", {30'd0, dbg_state_o}, 32'd2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 188'd0) begin
            failures++;
            $display("FAIL midop_reset_outputs: got 0x%047h expected all zero", all_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tmu_done_i = 1'b1;
        tmu_data_i = 32'h1111_2222;
        @(posedge clk); #1;
        tmu_done_i = 1'b0;
        tmu_data_i = 32'd0;
        check_val("post_reset_idle", {30'd0, dbg_state_o}, 32'd0);
        drain("reset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
